sad_accumulator: RTL and testbench
==================================

Name: sad_accumulator

Overview:
- Streaming sum-of-absolute-differences (SAD) stage for block-matching motion estimation.
- Accepts one pair of pixels per cycle (current pixel and reference pixel) and forms |cur - ref| for each pair.
- Accumulates BLOCK_SAMPLES differences into one SAD result and presents it on a valid/ready output.
- Sits downstream of the pixel fetch logic. It is the consumer stage whose running sum feeds the cla_16bits adder datapath.

Parameters:
- PIX_W, 8: pixel width, unsigned.
- SAD_W, 16: accumulator and result width.
- BLOCK_SAMPLES, 16: number of pixel pairs per block. Legal range 1..2^16-1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous abort. Discards the block in progress and returns to IDLE.
- in_valid, input, 1: pixel pair present.
- in_ready, output, 1: block can accept a pair.
- cur_pix, input, PIX_W: current-block pixel, unsigned.
- ref_pix, input, PIX_W: reference-block pixel, unsigned.
- out_valid, output, 1: SAD result valid.
- out_ready, input, 1: downstream accepts the result.
- sad_out, output, SAD_W: accumulated SAD.
- sad_sat, output, 1: result saturated.

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE.
  - Registers cleared: acc=0, cnt=0, sad_out=0, sad_sat=0, out_valid=0.
  - in_ready=1 is driven in IDLE once rst_n is high.
- Transfer: a pixel pair is accepted on a rising edge where in_valid and in_ready are both high.
- absdiff = (cur_pix >= ref_pix) ? cur_pix - ref_pix : ref_pix - cur_pix.
  - Width PIX_W, combinational.
  - absdiff is zero-extended to SAD_W+1 before the add.
- Saturating add: if acc + absdiff > 2^SAD_W - 1, acc becomes 2^SAD_W - 1 and the internal sat flag is set. Once set, the flag stays set until the block leaves DONE.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On accept: acc=absdiff, cnt=1, sat=0.
    - Goes to DONE if BLOCK_SAMPLES==1, otherwise to ACCUM.
  - ACCUM: in_ready=1.
    - On accept: acc=sat_add(acc, absdiff), cnt=cnt+1.
    - On the accept where cnt==BLOCK_SAMPLES-1: go to DONE.
    - Without accept: hold all registers.
  - DONE: in_ready=0, out_valid=1, sad_out and sad_sat hold the final values.
    - On out_ready: go to IDLE. acc, cnt and sat are cleared, while sad_out keeps its last value.
    - out_ready low: hold indefinitely with sad_out stable.
- Output registers:
  - sad_out and sad_sat are written on the cycle the final sample is accepted.
  - out_valid rises on the next clock edge, i.e. one cycle after the last accepted pair.
- Throughput: 1 pair/cycle within a block, plus a minimum 1-cycle DONE bubble per block.
- out_valid is never combinationally dependent on out_ready, and in_ready is never combinationally dependent on in_valid.
- clear:
  - Takes priority over every transfer in the same cycle.
  - From ACCUM: goes to IDLE, acc=0, cnt=0, sat=0, and a pair presented that cycle is discarded.
  - From DONE: the result is dropped, out_valid=0 next cycle, and the state goes to IDLE.
  - From IDLE: no effect beyond discarding a pair presented in that cycle.
- Reset mid-block: all partial state is lost. No out_valid is produced for the interrupted block.
- in_valid gaps inside a block do not reset cnt.
- Pixel values are sampled only on accepting edges.

Test Plan:
1. Basic accumulation (BLOCK_SAMPLES=16): 16 pairs with cur=10, ref=3 back-to-back -> out_valid rises 1 cycle after the 16th accept, sad_out=112, sad_sat=0. A second block with cur=3, ref=10 -> sad_out=112.
2. Mixed values with in_valid gaps: pairs (0,0),(255,0),(0,255),(128,127), each followed by one idle cycle, with BLOCK_SAMPLES=4 -> sad_out=511, and no out_valid before the 4th accept.
3. Saturation (SAD_W=10, BLOCK_SAMPLES=16): 16 pairs (255,0) -> sad_out=1023, sad_sat=1. The next block of (1,0) pairs -> sad_out=16, sad_sat=0.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sad_out stable, in_ready=0 throughout, and in_valid pairs offered are not consumed. Raise out_ready -> IDLE and in_ready=1 on the next cycle.
5. clear mid-block: 7 pairs (9,1), assert clear together with an 8th pair, then 16 pairs (2,1) -> sad_out=16. The first block produces no output.
6. Async reset: drop rst_n between clock edges mid-block and in DONE -> out_valid=0, sad_out=0 and in_ready=0 immediately. After release, a fresh 16-pair (5,5) block -> sad_out=0.

Source files
------------

// File: rtl/sad_accumulator.sv
// Streaming sum-of-absolute-differences stage: accumulates BLOCK_SAMPLES |cur - ref| terms
// per block with saturation and hands the result over a valid/ready output.
module sad_accumulator #(
   parameter int unsigned PIX_W         = 8,
   parameter int unsigned SAD_W         = 16,
   parameter int unsigned BLOCK_SAMPLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] cur_pix,
   input  logic [PIX_W-1:0] ref_pix,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SAD_W-1:0] sad_out,
   output logic             sad_sat
);

   localparam int unsigned   CntW    = 16;
   localparam logic [CntW-1:0] LastCnt = CntW'(BLOCK_SAMPLES - 1);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e           state_q;
   logic [SAD_W-1:0] acc_q;
   logic [CntW-1:0]  cnt_q;
   logic             sat_q;
   logic             out_valid_q;
   logic [SAD_W-1:0] sad_q;
   logic             sad_sat_q;

   logic             accept;
   logic             last;
   logic [PIX_W-1:0] absdiff;
   logic [SAD_W-1:0] acc_base;
   logic [SAD_W:0]   sum;
   logic [SAD_W-1:0] acc_next;
   logic             sat_next;

   // A new block starts from zero, so IDLE feeds the same saturating adder as ACCUM.
   always_comb begin
      absdiff  = (cur_pix >= ref_pix) ? cur_pix - ref_pix : ref_pix - cur_pix;
      acc_base = (state_q == StIdle) ? '0 : acc_q;
      sum      = {1'b0, acc_base} + (SAD_W + 1)'(absdiff);
      acc_next = sum[SAD_W] ? '1 : sum[SAD_W-1:0];
      sat_next = sum[SAD_W] | ((state_q != StIdle) & sat_q);
      last     = (state_q == StIdle) ? (BLOCK_SAMPLES == 1) : (cnt_q == LastCnt);
      accept   = in_valid & in_ready & ~clear;
   end

   // Gated by rst_n so the input side reads not-ready while reset is held.
   assign in_ready  = rst_n & (state_q != StDone);
   assign out_valid = out_valid_q;
   assign sad_out   = sad_q;
   assign sad_sat   = sad_sat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         sad_q       <= '0;
         sad_sat_q   <= 1'b0;
      end else if (clear) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StAccum: begin
               if (accept) begin
                  acc_q <= acc_next;
                  sat_q <= sat_next;
                  cnt_q <= cnt_q + CntW'(1);
                  if (last) begin
                     state_q     <= StDone;
                     out_valid_q <= 1'b1;
                     sad_q       <= acc_next;
                     sad_sat_q   <= sat_next;
                  end else begin
                     state_q <= StAccum;
                  end
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  sat_q       <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sad_accumulator.sv
// Bench for sad_accumulator: three instances (default, 4-sample block, 10-bit accumulator)
// driven by a vector table, directed corner sequences and random blocks vs. a sum model.
module tb_sad_accumulator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear     [3];
   logic       in_valid  [3];
   logic       in_ready  [3];
   logic       out_valid [3];
   logic       out_ready [3];
   logic       sad_sat   [3];
   logic [7:0] cur_pix   [3];
   logic [7:0] ref_pix   [3];
   logic [15:0] sad_a;
   logic [15:0] sad_b;
   logic [9:0]  sad_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sad_accumulator #(.PIX_W(8), .SAD_W(16), .BLOCK_SAMPLES(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .cur_pix(cur_pix[0]), .ref_pix(ref_pix[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sad_out(sad_a),
      .sad_sat(sad_sat[0])
   );

   sad_accumulator #(.PIX_W(8), .SAD_W(16), .BLOCK_SAMPLES(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .cur_pix(cur_pix[1]), .ref_pix(ref_pix[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sad_out(sad_b),
      .sad_sat(sad_sat[1])
   );

   sad_accumulator #(.PIX_W(8), .SAD_W(10), .BLOCK_SAMPLES(16)) dut_c (
      .clk(clk), .rst_n(rst_n), .clear(clear[2]), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .cur_pix(cur_pix[2]), .ref_pix(ref_pix[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sad_out(sad_c),
      .sad_sat(sad_sat[2])
   );

   typedef struct packed {
      logic [3:0][7:0] c;
      logic [3:0][7:0] r;
      logic [15:0]     sad;
      logic            sat;
      logic [1:0]      gap;
   } vec_t;

   vec_t vecs [4];

   function automatic logic [15:0] sad_of(input int idx);
      case (idx)
         0:       return sad_a;
         1:       return sad_b;
         default: return {6'b0, sad_c};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle gap cycles, then one pair that must be accepted on the next edge.
   task automatic send(input int idx, input logic [7:0] c, input logic [7:0] r, input int gap);
      for (int g = 0; g < gap; g++) begin
         in_valid[idx] = 1'b0;
         check("gap_in_ready", 32'(in_ready[idx]), 1);
         check("gap_out_valid", 32'(out_valid[idx]), 0);
         tick();
      end
      in_valid[idx] = 1'b1;
      cur_pix[idx]  = c;
      ref_pix[idx]  = r;
      check("accept_in_ready", 32'(in_ready[idx]), 1);
      check("early_out_valid", 32'(out_valid[idx]), 0);
      tick();
      in_valid[idx] = 1'b0;
      cur_pix[idx]  = 8'($urandom);
      ref_pix[idx]  = 8'($urandom);
   endtask

   // Checks the result the cycle after the last accept, stalls `hold` cycles offering
   // pairs that must be ignored, then releases it.
   task automatic result(input int idx, input int exp_sad, input bit exp_sat, input int hold);
      check("out_valid", 32'(out_valid[idx]), 1);
      check("sad_out", 32'(sad_of(idx)), exp_sad);
      check("sad_sat", 32'(sad_sat[idx]), 32'(exp_sat));
      check("done_in_ready", 32'(in_ready[idx]), 0);
      for (int h = 0; h < hold; h++) begin
         in_valid[idx]  = 1'b1;
         cur_pix[idx]   = 8'($urandom);
         ref_pix[idx]   = 8'($urandom);
         out_ready[idx] = 1'b0;
         tick();
         check("hold_out_valid", 32'(out_valid[idx]), 1);
         check("hold_sad_out", 32'(sad_of(idx)), exp_sad);
         check("hold_in_ready", 32'(in_ready[idx]), 0);
      end
      in_valid[idx]  = 1'b0;
      out_ready[idx] = 1'b1;
      tick();
      out_ready[idx] = 1'b0;
      check("release_out_valid", 32'(out_valid[idx]), 0);
      check("release_in_ready", 32'(in_ready[idx]), 1);
   endtask

   task automatic const_block(input int idx, input int n, input logic [7:0] c,
                              input logic [7:0] r);
      for (int i = 0; i < n; i++) send(idx, c, r, 0);
   endtask

   // Reference: the block SAD is the plain sum of |c-r|, clipped to the result range.
   task automatic rand_block(input int idx, input int n, input int maxv);
      int sum;
      int lim;
      int c;
      int r;
      sum = 0;
      lim = int'($urandom_range(255, 16));
      for (int i = 0; i < n; i++) begin
         c = int'($urandom_range(lim, 0));
         r = int'($urandom_range(lim, 0));
         sum += (c >= r) ? c - r : r - c;
         send(idx, 8'(c), 8'(r), int'($urandom_range(2, 0)));
      end
      result(idx, (sum > maxv) ? maxv : sum, sum > maxv, int'($urandom_range(3, 0)));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{c: {8'd128, 8'd0, 8'd255, 8'd0}, r: {8'd127, 8'd255, 8'd0, 8'd0},
                  sad: 16'd511, sat: 1'b0, gap: 2'd1};
      vecs[1] = '{c: {8'd200, 8'd10, 8'd3, 8'd1}, r: {8'd100, 8'd4, 8'd3, 8'd2},
                  sad: 16'd107, sat: 1'b0, gap: 2'd0};
      vecs[2] = '{c: {4{8'd255}}, r: {4{8'd255}}, sad: 16'd0, sat: 1'b0, gap: 2'd0};
      vecs[3] = '{c: {4{8'd0}}, r: {4{8'd255}}, sad: 16'd1020, sat: 1'b0, gap: 2'd2};

      for (int i = 0; i < 3; i++) begin
         clear[i]     = 1'b0;
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
         cur_pix[i]   = '0;
         ref_pix[i]   = '0;
      end
      rst_n = 1'b0;
      #12;
      for (int i = 0; i < 3; i++) begin
         check("rst_in_ready_low", 32'(in_ready[i]), 0);
         check("rst_out_valid", 32'(out_valid[i]), 0);
         check("rst_sad_out", 32'(sad_of(i)), 0);
         check("rst_sad_sat", 32'(sad_sat[i]), 0);
      end
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) check("rst_in_ready_high", 32'(in_ready[i]), 1);
      tick();

      // Basic accumulation, both difference directions.
      const_block(0, 16, 8'd10, 8'd3);
      result(0, 112, 1'b0, 0);
      const_block(0, 16, 8'd3, 8'd10);
      result(0, 112, 1'b0, 0);

      // Vector table on the 4-sample instance.
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) send(1, vecs[i].c[j], vecs[i].r[j], int'(vecs[i].gap));
         result(1, int'(vecs[i].sad), vecs[i].sat, i);
      end

      // Saturation on the 10-bit instance, and the flag clearing for the next block.
      const_block(2, 16, 8'd255, 8'd0);
      result(2, 1023, 1'b1, 0);
      const_block(2, 16, 8'd1, 8'd0);
      result(2, 16, 1'b0, 0);

      // Backpressure: offered pairs during the stall must not leak into the next block.
      const_block(0, 16, 8'd7, 8'd2);
      result(0, 80, 1'b0, 5);
      const_block(0, 16, 8'd4, 8'd0);
      result(0, 64, 1'b0, 0);

      // clear mid-block, with a pair presented in the same cycle.
      const_block(0, 7, 8'd9, 8'd1);
      in_valid[0] = 1'b1;
      cur_pix[0]  = 8'd9;
      ref_pix[0]  = 8'd1;
      clear[0]    = 1'b1;
      tick();
      clear[0]    = 1'b0;
      in_valid[0] = 1'b0;
      check("clr_accum_out_valid", 32'(out_valid[0]), 0);
      check("clr_accum_in_ready", 32'(in_ready[0]), 1);
      const_block(0, 16, 8'd2, 8'd1);
      result(0, 16, 1'b0, 0);

      // clear in DONE drops the result.
      const_block(0, 16, 8'd3, 8'd1);
      check("pre_clr_out_valid", 32'(out_valid[0]), 1);
      clear[0] = 1'b1;
      tick();
      clear[0] = 1'b0;
      check("clr_done_out_valid", 32'(out_valid[0]), 0);
      check("clr_done_in_ready", 32'(in_ready[0]), 1);

      // clear in IDLE discards the presented pair.
      in_valid[0] = 1'b1;
      cur_pix[0]  = 8'd200;
      ref_pix[0]  = 8'd0;
      clear[0]    = 1'b1;
      tick();
      clear[0]    = 1'b0;
      in_valid[0] = 1'b0;
      const_block(0, 16, 8'd1, 8'd0);
      result(0, 16, 1'b0, 0);

      // Asynchronous reset mid-block.
      const_block(0, 5, 8'd9, 8'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_mid_out_valid", 32'(out_valid[0]), 0);
      check("arst_mid_in_ready", 32'(in_ready[0]), 0);
      #2 rst_n = 1'b1;
      tick();
      const_block(0, 16, 8'd10, 8'd3);
      check("post_arst_out_valid", 32'(out_valid[0]), 1);
      check("post_arst_sad", 32'(sad_a), 112);

      // Asynchronous reset while holding a result in DONE.
      #2 rst_n = 1'b0;
      #1;
      check("arst_done_out_valid", 32'(out_valid[0]), 0);
      check("arst_done_sad_out", 32'(sad_a), 0);
      check("arst_done_in_ready", 32'(in_ready[0]), 0);
      #2 rst_n = 1'b1;
      tick();
      check("arst_rel_in_ready", 32'(in_ready[0]), 1);
      const_block(0, 16, 8'd5, 8'd5);
      result(0, 0, 1'b0, 0);

      // Random blocks against the reference model.
      for (int k = 0; k < 10; k++) rand_block(0, 16, 65535);
      for (int k = 0; k < 10; k++) rand_block(1, 4, 65535);
      for (int k = 0; k < 10; k++) rand_block(2, 16, 1023);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
